// File: rtl/eth_fcs_checker.sv
// Ethernet FCS checker: removes the 4 trailing FCS bytes from a GMII byte
// stream through a 4-deep delay line, checks the CRC-32 residue, and reports
// per-frame length, FCS and abort status.
module eth_fcs_checker #(
    parameter int unsigned DATA_W          = 8,
    parameter int unsigned MIN_FRAME_BYTES = 64,
    parameter int unsigned MAX_FRAME_BYTES = 1518
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    input  logic              in_last,
    input  logic              in_abort,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              stat_valid,
    output logic              stat_fcs_err,
    output logic              stat_len_err,
    output logic              stat_abort,
    output logic [10:0]       stat_len
);

    typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

    localparam logic [31:0] CRC_INIT    = '1;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [10:0] LEN_SAT     = '1;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] dl [4];
    logic [DATA_W-1:0] dl_nxt [4];
    logic [10:0]       count, count_nxt, count_inc;
    logic [31:0]       crc, crc_nxt, crc_upd, crc_first;

    logic              ov_nxt, ol_nxt, sv_nxt, sf_nxt, sl_nxt, sa_nxt;
    logic [DATA_W-1:0] od_nxt;
    logic [10:0]       len_nxt;

    // Reflected CRC-32, one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c_in,
                                               input logic [DATA_W-1:0] d);
        logic [31:0] c;
        c = c_in ^ 32'(d);
        for (int unsigned i = 0; i < DATA_W; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic len_bad(input logic [10:0] n);
        return (32'(n) < MIN_FRAME_BYTES) || (32'(n) > MAX_FRAME_BYTES);
    endfunction

    // Next-state, delay line, CRC, counters and registered output values.
    always_comb begin
        state_nxt = state;
        dl_nxt    = dl;
        count_nxt = count;
        crc_nxt   = crc;
        ov_nxt    = 1'b0;
        od_nxt    = out_data;
        ol_nxt    = 1'b0;
        sv_nxt    = 1'b0;
        sf_nxt    = stat_fcs_err;
        sl_nxt    = stat_len_err;
        sa_nxt    = stat_abort;
        len_nxt   = stat_len;

        count_inc = (count == LEN_SAT) ? count : count + 11'd1;
        crc_upd   = crc32_byte(crc, in_data);
        crc_first = crc32_byte(CRC_INIT, in_data);

        case (state)
            IDLE: begin
                if (in_valid && in_sof) begin
                    dl_nxt[0] = in_data;
                    count_nxt = 11'd1;
                    crc_nxt   = crc_first;
                    state_nxt = FILL;
                    if (in_last) begin
                        sv_nxt    = 1'b1;
                        sf_nxt    = (crc_first != CRC_RESIDUE);
                        sl_nxt    = len_bad(11'd1);
                        sa_nxt    = 1'b0;
                        len_nxt   = 11'd1;
                        state_nxt = IDLE;
                    end
                end
            end
            FILL, STREAM: begin
                if (in_valid) begin
                    if (in_abort || in_sof) begin
                        // Close the running frame as aborted; a plain sof
                        // (no abort) restarts a frame with this same byte.
                        sv_nxt    = 1'b1;
                        sf_nxt    = 1'b0;
                        sl_nxt    = 1'b0;
                        sa_nxt    = 1'b1;
                        len_nxt   = count;
                        state_nxt = IDLE;
                        if (!in_abort) begin
                            dl_nxt[0] = in_data;
                            count_nxt = 11'd1;
                            crc_nxt   = crc_first;
                            state_nxt = in_last ? IDLE : FILL;
                        end
                    end else begin
                        dl_nxt[3] = dl[2];
                        dl_nxt[2] = dl[1];
                        dl_nxt[1] = dl[0];
                        dl_nxt[0] = in_data;
                        count_nxt = count_inc;
                        crc_nxt   = crc_upd;
                        if (state == STREAM) begin
                            ov_nxt = 1'b1;
                            od_nxt = dl[3];
                        end
                        if (in_last) begin
                            sv_nxt    = 1'b1;
                            sf_nxt    = (crc_upd != CRC_RESIDUE);
                            sl_nxt    = len_bad(count_inc);
                            sa_nxt    = 1'b0;
                            len_nxt   = count_inc;
                            ol_nxt    = (state == STREAM);
                            state_nxt = IDLE;
                        end else if (state == FILL && count_inc == 11'd4) begin
                            state_nxt = STREAM;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 4; i++) dl[i] <= '0;
            count        <= '0;
            crc          <= CRC_INIT;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_last     <= 1'b0;
            stat_valid   <= 1'b0;
            stat_fcs_err <= 1'b0;
            stat_len_err <= 1'b0;
            stat_abort   <= 1'b0;
            stat_len     <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) dl[i] <= dl_nxt[i];
            count        <= count_nxt;
            crc          <= crc_nxt;
            out_valid    <= ov_nxt;
            out_data     <= od_nxt;
            out_last     <= ol_nxt;
            stat_valid   <= sv_nxt;
            stat_fcs_err <= sf_nxt;
            stat_len_err <= sl_nxt;
            stat_abort   <= sa_nxt;
            stat_len     <= len_nxt;
        end
    end

endmodule
